// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART 8N1 boot loader writing a word image into instruction memory
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMEM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   MAX_WORDS = 17'(IMEM_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_HDR0, L_HDR1, L_DATA, L_WRITE, L_DONE, L_ERROR} ld_state_t;

    rx_state_t       rx_state, rx_state_next;
    ld_state_t       ld_state, ld_state_next;
    logic [1:0]      rx_sync;
    logic            rx_s, rx_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;
    logic            tick, byte_valid, framing_err;
    logic [7:0]      n_lo;
    logic [15:0]     n_words, hdr_n, word_idx;
    logic [1:0]      byte_cnt;
    logic [31:0]     word_buf;

    assign rx_s  = rx_sync[1];
    assign hdr_n = {rx_shift, n_lo};

    // Two-flop synchronizer plus previous-value flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_next;
    end

    // RX next state; sample ticks land mid-bit, byte/framing pulses come from the stop sample
    always_comb begin
        rx_state_next = rx_state;
        tick          = 1'b0;
        byte_valid    = 1'b0;
        framing_err   = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_s && rx_prev) rx_state_next = RX_START;
            RX_START: if (cnt == HALF_LAST) begin
                tick          = 1'b1;
                rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (cnt == FULL_LAST) begin
                tick = 1'b1;
                if (bit_idx == 3'd7) rx_state_next = RX_STOP;
            end
            RX_STOP:  if (cnt == FULL_LAST) begin
                tick          = 1'b1;
                byte_valid    = rx_s;
                framing_err   = !rx_s;
                rx_state_next = RX_IDLE;
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    // Bit timing counter and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            cnt <= (rx_state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && tick) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    // Loader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ld_state <= L_HDR0;
        else        ld_state <= ld_state_next;
    end

    // Loader next state; DONE and ERROR are terminal until reset
    always_comb begin
        ld_state_next = ld_state;
        case (ld_state)
            L_HDR0:  if (framing_err) ld_state_next = L_ERROR;
                     else if (byte_valid) ld_state_next = L_HDR1;
            L_HDR1:  if (framing_err) ld_state_next = L_ERROR;
                     else if (byte_valid)
                         ld_state_next = (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_WORDS) ? L_ERROR : L_DATA;
            L_DATA:  if (framing_err) ld_state_next = L_ERROR;
                     else if (byte_valid && byte_cnt == 2'd3) ld_state_next = L_WRITE;
            L_WRITE: ld_state_next = (word_idx == n_words - 16'd1) ? L_DONE : L_DATA;
            L_DONE:  ld_state_next = L_DONE;
            L_ERROR: ld_state_next = L_ERROR;
            default: ld_state_next = L_ERROR;
        endcase
    end

    // Header latch, word assembly and write address/data staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lo       <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (ld_state == L_HDR0 && byte_valid) n_lo <= rx_shift;
            if (ld_state == L_HDR1 && byte_valid) n_words <= hdr_n;
            if (ld_state == L_DATA && byte_valid) begin
                byte_cnt <= byte_cnt + 1'b1;
                word_buf <= {rx_shift, word_buf[31:8]};
                if (byte_cnt == 2'd3) begin
                    imem_wdata <= {rx_shift, word_buf[31:8]};
                    imem_addr  <= {14'd0, word_idx, 2'b00};
                end
            end
            if (ld_state == L_WRITE) word_idx <= word_idx + 1'b1;
        end
    end

    assign imem_we    = (ld_state == L_WRITE);
    assign load_done  = (ld_state == L_DONE);
    assign load_error = (ld_state == L_ERROR);
    assign core_rst_n = (ld_state == L_DONE);
endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - directed bench for uart_program_loader
module tb_uart_program_loader;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        core_rst_n, load_done, load_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    logic done_prev = 1'b0;
    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];

    uart_program_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we === 1'b1) begin
            if (wr_count < 64) begin
                wa[wr_count] = imem_addr;
                wd[wr_count] = imem_wdata;
            end
            wr_count    = wr_count + 1;
            last_we_cyc = cyc;
        end
        if (load_done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
        done_prev = load_done;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", imem_we); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", imem_wdata); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n got %b exp 0", core_rst_n); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", load_error); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_two_words();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
        repeat (10) @(negedge clk);
        checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL two_count got %0d exp 2", wr_count - base); end
        checks++; if (wa[base] !== 32'h0) begin errors++; $display("FAIL two_addr0 got %h exp 0", wa[base]); end
        checks++; if (wd[base] !== 32'h00500093) begin errors++; $display("FAIL two_data0 got %h exp 00500093", wd[base]); end
        checks++; if (wa[base+1] !== 32'h4) begin errors++; $display("FAIL two_addr1 got %h exp 4", wa[base+1]); end
        checks++; if (wd[base+1] !== 32'h00A00113) begin errors++; $display("FAIL two_data1 got %h exp 00a00113", wd[base+1]); end
        checks++; if (done_cyc !== last_we_cyc + 1) begin errors++; $display("FAIL two_done_latency got %0d exp %0d", done_cyc, last_we_cyc + 1); end
        checks++; if (load_done !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL two_done got done=%b core=%b exp 1 1", load_done, core_rst_n); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL two_error got %b exp 0", load_error); end
        checks++; if (imem_wdata !== 32'h00A00113) begin errors++; $display("FAIL two_hold got %h exp 00a00113", imem_wdata); end
    endtask

    task automatic test_zero_header();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h00); send_byte(8'h00);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL zero_error got %b exp 1", load_error); end
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        repeat (5) @(negedge clk);
        checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL zero_writes got %0d exp 0", wr_count - base); end
        checks++; if (core_rst_n !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL zero_core got core=%b done=%b exp 0 0", core_rst_n, load_done); end
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL zero_sticky got %b exp 1", load_error); end
    endtask

    task automatic test_capacity();
        int base;
        do_reset();
        send_byte(8'h05); send_byte(8'h00);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL cap_over got %b exp 1", load_error); end
        do_reset();
        base = wr_count;
        send_byte(8'h04); send_byte(8'h00);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                send_byte(8'(k * 16 + j));
        repeat (5) @(negedge clk);
        checks++; if (wr_count - base !== 4) begin errors++; $display("FAIL cap_count got %0d exp 4", wr_count - base); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_d;
            logic [7:0]  b0;
            b0 = 8'(k * 16);
            exp_d = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
            checks++; if (wa[base+k] !== 32'(k * 4)) begin errors++; $display("FAIL cap_addr%0d got %h exp %h", k, wa[base+k], k * 4); end
            checks++; if (wd[base+k] !== exp_d) begin errors++; $display("FAIL cap_data%0d got %h exp %h", k, wd[base+k], exp_d); end
        end
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL cap_done got done=%b err=%b exp 1 0", load_done, load_error); end
    endtask

    task automatic test_framing();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        send_frame(8'h50, 1'b0);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL frame_error got %b exp 1", load_error); end
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        repeat (5) @(negedge clk);
        checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL frame_writes got %0d exp 0", wr_count - base); end
        checks++; if (core_rst_n !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL frame_core got core=%b done=%b exp 0 0", core_rst_n, load_done); end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = wr_count;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL glitch_error got %b exp 0", load_error); end
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        repeat (5) @(negedge clk);
        checks++; if (wr_count - base !== 1) begin errors++; $display("FAIL glitch_count got %0d exp 1", wr_count - base); end
        checks++; if (wd[base] !== 32'hDEADBEEF || wa[base] !== 32'h0) begin errors++; $display("FAIL glitch_word got %h@%h exp deadbeef@0", wd[base], wa[base]); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL glitch_done got %b exp 1", load_done); end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        repeat (3) @(negedge clk);
        checks++; if (wr_count - base !== 1) begin errors++; $display("FAIL mid_first got %0d exp 1", wr_count - base); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_wdata !== 32'h0 || imem_addr !== 32'h0 || imem_we !== 1'b0) begin errors++; $display("FAIL mid_async got we=%b addr=%h data=%h exp 0", imem_we, imem_addr, imem_wdata); end
        checks++; if (core_rst_n !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL mid_flags got core=%b done=%b err=%b exp 0", core_rst_n, load_done, load_error); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        base = wr_count;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
        repeat (5) @(negedge clk);
        checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL mid_count got %0d exp 2", wr_count - base); end
        checks++; if (wa[base] !== 32'h0 || wa[base+1] !== 32'h4) begin errors++; $display("FAIL mid_addr got %h %h exp 0 4", wa[base], wa[base+1]); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL mid_done got %b exp 1", load_done); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_header();
        test_capacity();
        test_framing();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
